// File: rtl/wb_mem_arbiter_pkg.sv
// Shared widths, state/master encodings and tie-break helper for the Wishbone memory arbiter.
package wb_mem_arbiter_pkg;

    localparam int unsigned WB_ADR_W = 12;
    localparam int unsigned WB_DAT_W = 128;
    localparam int unsigned WB_SEL_W = 16;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_IMEM = 2'd1,
        ARB_DMEM = 2'd2
    } arb_state_t;

    typedef enum logic {
        IMEM = 1'b0,
        DMEM = 1'b1
    } arb_master_t;

    // Winner when both masters request in the same idle cycle.
    function automatic arb_master_t arb_tie_winner(input logic rr_en, input arb_master_t last);
        if (rr_en) begin
            return (last == IMEM) ? DMEM : IMEM;
        end
        return DMEM;
    endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Granted-cycle watchdog: counts enabled cycles and flags the TIMEOUT_CYCLES-th one.
module wb_arb_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic timeout_o
);

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The counter holds the number of granted cycles already elapsed, so the
    // current cycle is the TIMEOUT_CYCLES-th one when it equals TIMEOUT_CYCLES-1.
    assign timeout_o = (TIMEOUT_CYCLES != 0) && en_i && (cnt_q == LastCnt);

endmodule

// File: rtl/wb_mem_arbiter.sv
// Two-to-one Wishbone arbiter sharing one line-wide memory port between imem and dmem.
// Define WB_ARB_ROUND_ROBIN_EN for alternating tie-breaks; otherwise dmem wins ties.
module wb_mem_arbiter
    import wb_mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WB_ADR_W-1:0] imem_adr,
    input  logic                imem_cyc,
    input  logic                imem_stb,
    output logic [WB_DAT_W-1:0] imem_dat_s,
    output logic                imem_ack,
    output logic                imem_rty,
    input  logic [WB_ADR_W-1:0] dmem_adr,
    input  logic [WB_DAT_W-1:0] dmem_dat_m,
    input  logic [WB_SEL_W-1:0] dmem_sel,
    input  logic                dmem_we,
    input  logic                dmem_cyc,
    input  logic                dmem_stb,
    output logic [WB_DAT_W-1:0] dmem_dat_s,
    output logic                dmem_ack,
    output logic                dmem_rty,
    output logic [WB_ADR_W-1:0] mem_adr,
    output logic [WB_DAT_W-1:0] mem_dat_m,
    output logic [WB_SEL_W-1:0] mem_sel,
    output logic                mem_we,
    output logic                mem_cyc,
    output logic                mem_stb,
    input  logic [WB_DAT_W-1:0] mem_dat_s,
    input  logic                mem_ack,
    input  logic                mem_rty
);

`ifdef WB_ARB_ROUND_ROBIN_EN
    localparam logic RrEn = 1'b1;
`else
    localparam logic RrEn = 1'b0;
`endif

    arb_state_t  state_q, state_d;
    arb_master_t last_grant_q, last_grant_d;

    logic imem_req, dmem_req;
    logic grant_imem, grant_dmem, granted;
    logic timeout, abort, done;
    logic resp_ack, resp_rty;

    assign imem_req = imem_cyc & imem_stb;
    assign dmem_req = dmem_cyc & dmem_stb;

    // Gating with rst_n drops an in-flight cycle and its response immediately.
    assign grant_imem = rst_n & (state_q == ARB_IMEM);
    assign grant_dmem = rst_n & (state_q == ARB_DMEM);
    assign granted    = grant_imem | grant_dmem;

    assign abort    = grant_imem ? ~imem_cyc : ~dmem_cyc;
    assign done     = granted & (mem_ack | mem_rty | timeout | abort);
    assign resp_ack = mem_ack & ~timeout;
    assign resp_rty = timeout | (mem_rty & ~mem_ack);

    wb_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_watchdog (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .clr_i    (done | ~granted),
        .en_i     (granted),
        .timeout_o(timeout)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ARB_IDLE: begin
                if (imem_req && dmem_req) begin
                    state_d = (arb_tie_winner(RrEn, last_grant_q) == DMEM) ? ARB_DMEM : ARB_IMEM;
                end else if (imem_req) begin
                    state_d = ARB_IMEM;
                end else if (dmem_req) begin
                    state_d = ARB_DMEM;
                end
            end
            ARB_IMEM, ARB_DMEM: begin
                if (done) begin
                    state_d      = ARB_IDLE;
                    last_grant_d = (state_q == ARB_DMEM) ? DMEM : IMEM;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= IMEM;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        mem_adr    = '0;
        mem_dat_m  = '0;
        mem_sel    = '0;
        mem_we     = 1'b0;
        mem_cyc    = 1'b0;
        mem_stb    = 1'b0;
        imem_dat_s = '0;
        imem_ack   = 1'b0;
        imem_rty   = 1'b0;
        dmem_dat_s = '0;
        dmem_ack   = 1'b0;
        dmem_rty   = 1'b0;
        if (grant_dmem) begin
            mem_adr    = dmem_adr;
            mem_dat_m  = dmem_dat_m;
            mem_sel    = dmem_sel;
            mem_we     = dmem_we;
            mem_cyc    = dmem_cyc & ~timeout;
            mem_stb    = dmem_stb & ~timeout;
            dmem_dat_s = mem_dat_s;
            dmem_ack   = resp_ack;
            dmem_rty   = resp_rty;
        end else if (grant_imem) begin
            mem_adr    = imem_adr;
            mem_cyc    = imem_cyc & ~timeout;
            mem_stb    = imem_stb & ~timeout;
            imem_dat_s = mem_dat_s;
            imem_ack   = resp_ack;
            imem_rty   = resp_rty;
        end
    end

endmodule

// File: doc/wb_mem_arbiter.md
Name: wb_mem_arbiter

Overview:
Two-to-one Wishbone arbiter that shares a single 128-bit line-wide memory port between the CPU instruction master (imem) and data master (dmem).
- Grants one requester at a time and holds the grant for a whole bus cycle.
- Passes ACK/RTY and read data back only to the granted master.
- Aborts a stalled cycle with a watchdog timeout.
- Sits between the cpu wishbone masters and the physical memory/L2 slave.

Parameters:
TIMEOUT_CYCLES, 255, cycles a granted cycle may wait for mem ACK/RTY before forced retry; 0 disables the watchdog.
CNT_W, 8, watchdog counter width; must satisfy 2**CNT_W > TIMEOUT_CYCLES.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
imem_adr  input  12  imem line address (byte address [15:4])
imem_cyc / imem_stb  input  1 each  imem cycle/strobe
imem_dat_s  output  128  read data to imem
imem_ack / imem_rty  output  1 each  imem acknowledge/retry
dmem_adr  input  12  dmem line address
dmem_dat_m  input  128  dmem write data
dmem_sel  input  16  dmem byte selects
dmem_we  input  1  dmem write enable
dmem_cyc / dmem_stb  input  1 each  dmem cycle/strobe
dmem_dat_s  output  128  read data to dmem
dmem_ack / dmem_rty  output  1 each  dmem acknowledge/retry
mem_adr  output  12  shared port address
mem_dat_m  output  128  shared port write data
mem_sel  output  16  shared port byte selects
mem_we / mem_cyc / mem_stb  output  1 each  shared port controls
mem_dat_s  input  128  shared port read data
mem_ack / mem_rty  input  1 each  shared port acknowledge/retry

Behaviour:
- A request is present when the master's cyc & stb = 1.
- Reset (rst_n=0 at a clk edge): state=ARB_IDLE, watchdog=0, last_grant=IMEM.
  - All mem_* outputs are 0.
  - All *_ack, *_rty and *_dat_s outputs are 0.
  - Reset has priority over every event, including mid-cycle; an in-flight mem cycle is dropped without ACK to either master.
- States: ARB_IDLE, ARB_IMEM, ARB_DMEM.
- ARB_IDLE:
  - mem_cyc = mem_stb = 0.
  - Only imem requesting -> ARB_IMEM. Only dmem requesting -> ARB_DMEM.
  - Both requesting -> resolved by the arbitration policy (see Optional Feature).
  - Arbitration latency: exactly one cycle from request to mem_stb.
- ARB_IMEM / ARB_DMEM, while granted:
  - mem_adr, mem_cyc and mem_stb mirror the granted master combinationally.
  - mem_dat_m, mem_sel and mem_we mirror dmem when dmem is granted; they are forced to 0 when imem is granted (imem never writes).
  - mem_ack, mem_rty and mem_dat_s route combinationally to the granted master only.
  - The non-granted master sees ack=rty=0 and dat_s=0.
- Cycle termination (mem_ack | mem_rty) -> ARB_IDLE next cycle. last_grant is updated; the watchdog is cleared.
  - If both mem_ack and mem_rty are asserted, ACK wins and RTY is masked.
- Abort: granted master drops cyc -> ARB_IDLE next cycle, no response generated, last_grant updated.
- Watchdog:
  - Counts each granted cycle with no termination.
  - When it reaches TIMEOUT_CYCLES: the arbiter asserts the granted master's rty for one cycle, drives mem_cyc=0 that same cycle, then goes to ARB_IDLE.
- A master keeping its request asserted after termination re-arbitrates from ARB_IDLE; there is always at least one idle cycle between grants.

Optional Feature:
WB_ARB_ROUND_ROBIN_EN
- Defined: on simultaneous requests in ARB_IDLE, grant the master not in last_grant (alternating fairness).
- Undefined: fixed priority, dmem always wins ties; last_grant is still maintained but ignored.

Decomposition:
- Add to lc3b_types:
  - widths WB_ADR_W=12, WB_DAT_W=128, WB_SEL_W=16;
  - enum arb_state_t {ARB_IDLE, ARB_IMEM, ARB_DMEM};
  - enum arb_master_t {IMEM, DMEM}.
- One sub-module, wb_arb_watchdog: CNT_W counter with clear/enable inputs and a timeout pulse output.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with both masters requesting -> all outputs 0, state ARB_IDLE; first grant occurs on the cycle after rst_n=1.
- Single imem read: imem_adr=12'h0A3, mem_ack after 4 cycles with mem_dat_s=128'hDEAD...BEEF -> mem_adr=12'h0A3, mem_we=0, mem_sel=0; imem_ack and imem_dat_s match for 1 cycle; dmem_ack=0.
- dmem write: dmem_adr=12'h123, dmem_sel=16'h0030, dmem_we=1 -> mem_sel=16'h0030, mem_we=1, dmem_ack returned; the arbiter is back in ARB_IDLE next cycle.
- Simultaneous requests held for 4 transactions -> with WB_ARB_ROUND_ROBIN_EN grant order D,I,D,I; without it D,D,D,D while dmem keeps requesting.
- Watchdog: TIMEOUT_CYCLES=8 and mem never responds -> granted master sees rty=1 on the 8th granted cycle and mem_cyc=0 that cycle; mem_rty=1 with mem_ack=1 -> ack only.
- Abort: dmem drops cyc 2 cycles into its grant while imem is pending -> mem_cyc=0 next cycle, no dmem_ack; imem is granted one cycle later.
